// File: rtl/hwpe_ctrl_vfpu_package.sv
// +----------------------------------------------------------------------+
// | hwpe_ctrl_vfpu_package                                               |
// | Shared types and constants for the VFPU job sequencer.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package hwpe_ctrl_vfpu_package;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

    localparam int unsigned ELEM_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/vfpu_chunk_addr_adv.sv
// +----------------------------------------------------------------------+
// | vfpu_chunk_addr_adv                                                  |
// | Working base addresses for A, B and result; advance per chunk.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vfpu_chunk_addr_adv
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned CHUNK_WIDTH    = 16,
    parameter int unsigned BYTES_PER_ELEM = ELEM_BYTES
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic                   adv_i,
    input  logic [ADDR_WIDTH-1:0]  base_a_i,
    input  logic [ADDR_WIDTH-1:0]  base_b_i,
    input  logic [ADDR_WIDTH-1:0]  base_res_i,
    input  logic [CHUNK_WIDTH-1:0] incr_elems_i,
    output logic [ADDR_WIDTH-1:0]  base_a_o,
    output logic [ADDR_WIDTH-1:0]  base_b_o,
    output logic [ADDR_WIDTH-1:0]  base_res_o
);

    logic [ADDR_WIDTH-1:0] base_a_q;
    logic [ADDR_WIDTH-1:0] base_b_q;
    logic [ADDR_WIDTH-1:0] base_res_q;
    logic [ADDR_WIDTH-1:0] incr_d;

    // One shared byte increment for all three streams; wraps silently.
    assign incr_d = ADDR_WIDTH'(incr_elems_i) * ADDR_WIDTH'(BYTES_PER_ELEM);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_a_q   <= '0;
            base_b_q   <= '0;
            base_res_q <= '0;
        end else if (load_i) begin
            base_a_q   <= base_a_i;
            base_b_q   <= base_b_i;
            base_res_q <= base_res_i;
        end else if (adv_i) begin
            base_a_q   <= base_a_q + incr_d;
            base_b_q   <= base_b_q + incr_d;
            base_res_q <= base_res_q + incr_d;
        end
    end

    assign base_a_o   = base_a_q;
    assign base_b_o   = base_b_q;
    assign base_res_o = base_res_q;

endmodule

`default_nettype wire

// File: rtl/vfpu_job_sequencer.sv
// +----------------------------------------------------------------------+
// | vfpu_job_sequencer                                                   |
// | Splits a VFPU job into chunks and sequences the streamers per chunk. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vfpu_job_sequencer
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 32,
    parameter int unsigned CHUNK_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH-1:0]  base_a_i,
    input  logic [ADDR_WIDTH-1:0]  base_b_i,
    input  logic [ADDR_WIDTH-1:0]  base_res_i,
    input  logic [LEN_WIDTH-1:0]   total_len_i,
    input  logic [CHUNK_WIDTH-1:0] chunk_len_i,
    input  logic                   streams_ready_i,
    input  logic                   sink_done_i,
    output logic                   stream_start_o,
    output logic [ADDR_WIDTH-1:0]  base_a_o,
    output logic [ADDR_WIDTH-1:0]  base_b_o,
    output logic [ADDR_WIDTH-1:0]  base_res_o,
    output logic [CHUNK_WIDTH-1:0] trans_size_o,
    output logic [LEN_WIDTH-1:0]   chunk_idx_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    seq_state_t             state_q;
    logic [LEN_WIDTH-1:0]   remaining_q;
    logic [LEN_WIDTH-1:0]   chunk_idx_q;
    logic [CHUNK_WIDTH-1:0] trans_size_q;
    logic                   start_q;
    logic                   done_q;
    logic                   err_q;

    logic                   sync_rst_d;
    logic [LEN_WIDTH-1:0]   remaining_d;
    logic [CHUNK_WIDTH-1:0] trans_first_d;
    logic [CHUNK_WIDTH-1:0] trans_next_d;

    function automatic logic [CHUNK_WIDTH-1:0] clip_len(
        input logic [LEN_WIDTH-1:0]   rem,
        input logic [CHUNK_WIDTH-1:0] chunk
    );
        logic [LEN_WIDTH-1:0] chunk_ext;
        chunk_ext = LEN_WIDTH'(chunk);
        return (rem < chunk_ext) ? CHUNK_WIDTH'(rem) : chunk;
    endfunction

    assign sync_rst_d    = rst_i | clear_i;
    assign remaining_d   = remaining_q - LEN_WIDTH'(trans_size_q);
    assign trans_first_d = clip_len(total_len_i, chunk_len_i);
    assign trans_next_d  = clip_len(remaining_d, chunk_len_i);

    // Empty and rejected jobs still pass through LAUNCH so that done_o trails
    // start_i by the same two cycles it trails the last sink_done_i.
    always_ff @(posedge clk_i) begin
        if (sync_rst_d) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            chunk_idx_q  <= '0;
            trans_size_q <= '0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        remaining_q  <= total_len_i;
                        chunk_idx_q  <= '0;
                        trans_size_q <= trans_first_d;
                        err_q        <= (chunk_len_i == '0);
                        state_q      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (err_q || (remaining_q == '0)) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (streams_ready_i) begin
                        start_q <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (sink_done_i) begin
                        state_q <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    remaining_q  <= remaining_d;
                    chunk_idx_q  <= chunk_idx_q + LEN_WIDTH'(1);
                    trans_size_q <= trans_next_d;
                    if (remaining_d == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= LAUNCH;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    vfpu_chunk_addr_adv #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CHUNK_WIDTH    (CHUNK_WIDTH),
        .BYTES_PER_ELEM (DATA_WIDTH / 8)
    ) u_addr_adv (
        .clk_i        (clk_i),
        .rst_i        (sync_rst_d),
        .load_i       ((state_q == IDLE) && start_i),
        .adv_i        (state_q == ADVANCE),
        .base_a_i     (base_a_i),
        .base_b_i     (base_b_i),
        .base_res_i   (base_res_i),
        .incr_elems_i (trans_size_q),
        .base_a_o     (base_a_o),
        .base_b_o     (base_b_o),
        .base_res_o   (base_res_o)
    );

    assign stream_start_o = start_q;
    assign trans_size_o   = trans_size_q;
    assign chunk_idx_o    = chunk_idx_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_vfpu_job_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_vfpu_job_sequencer                                                |
// | Scoreboard bench: expected chunk launches queued, popped on pulses.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_vfpu_job_sequencer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_a_i = '0;
    logic [31:0] base_b_i = '0;
    logic [31:0] base_res_i = '0;
    logic [31:0] total_len_i = '0;
    logic [15:0] chunk_len_i = '0;
    logic        streams_ready_i = 1'b1;
    logic        sink_done_i = 1'b0;
    logic        stream_start_o;
    logic [31:0] base_a_o;
    logic [31:0] base_b_o;
    logic [31:0] base_res_o;
    logic [15:0] trans_size_o;
    logic [31:0] chunk_idx_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    vfpu_job_sequencer #(
        .DATA_WIDTH (32), .ADDR_WIDTH (32), .LEN_WIDTH (32), .CHUNK_WIDTH (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .clear_i         (clear_i),
        .start_i         (start_i),
        .base_a_i        (base_a_i),
        .base_b_i        (base_b_i),
        .base_res_i      (base_res_i),
        .total_len_i     (total_len_i),
        .chunk_len_i     (chunk_len_i),
        .streams_ready_i (streams_ready_i),
        .sink_done_i     (sink_done_i),
        .stream_start_o  (stream_start_o),
        .base_a_o        (base_a_o),
        .base_b_o        (base_b_o),
        .base_res_o      (base_res_o),
        .trans_size_o    (trans_size_o),
        .chunk_idx_o     (chunk_idx_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ts;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int last_sink_cyc = 0;
    int sink_cnt = 0;
    bit auto_sink = 1'b1;
    bit sink_auto_drv = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor and sink-streamer model, sampled 2 time units after the edge.
    always @(posedge clk) begin
        #2;
        if (sink_auto_drv) begin
            sink_done_i = 1'b0;
            sink_auto_drv = 1'b0;
        end
        if (stream_start_o) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_start", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("trans_size", trans_size_o, mon_e.ts);
                check_eq("base_a", base_a_o, mon_e.a);
                check_eq("base_b", base_b_o, mon_e.b);
                check_eq("base_res", base_res_o, mon_e.r);
                check_eq("chunk_idx", chunk_idx_o, mon_e.idx);
            end
            if (auto_sink) sink_cnt = 5;
        end else if (sink_cnt > 0) begin
            sink_cnt--;
            if (sink_cnt == 0) begin
                sink_done_i = 1'b1;
                sink_auto_drv = 1'b1;
                last_sink_cyc = cyc;
            end
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic push_model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                              input logic [31:0] total, input logic [15:0] chunk, output int n);
        logic [31:0] rem;
        logic [31:0] ts;
        exp_t e;
        n = 0;
        rem = total;
        if (chunk != 0) begin
            while (rem != 0) begin
                ts = (rem < {16'd0, chunk}) ? rem : {16'd0, chunk};
                e.ts = ts[15:0]; e.a = a; e.b = b; e.r = r; e.idx = n;
                exp_q.push_back(e);
                a = a + ts * 4; b = b + ts * 4; r = r + ts * 4;
                rem = rem - ts;
                n++;
            end
        end
    endtask

    task automatic kick(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic [31:0] total, input logic [15:0] chunk);
        @(negedge clk);
        base_a_i = a; base_b_i = b; base_res_i = r;
        total_len_i = total; chunk_len_i = chunk;
        start_i = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int n, input int s0, input int d0, input bit exp_err);
        int i;
        for (i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        if (done_cnt == d0) check_eq({tag, "_done_timeout"}, 1, 0);
        if (n == 0) check_eq({tag, "_done_lat_start"}, done_cyc - start_cyc, 2);
        else        check_eq({tag, "_done_lat_sink"}, done_cyc - last_sink_cyc, 2);
        repeat (4) @(negedge clk);
        check_eq({tag, "_done_once"}, done_cnt - d0, 1);
        check_eq({tag, "_starts"}, start_cnt - s0, n);
        check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
        check_eq({tag, "_err"}, err_o, exp_err);
        check_eq({tag, "_idle"}, busy_o, 0);
    endtask

    task automatic run_job(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic [31:0] total,
                           input logic [15:0] chunk, input bit exp_err);
        int n;
        int s0;
        int d0;
        push_model(a, b, r, total, chunk, n);
        s0 = start_cnt; d0 = done_cnt;
        kick(a, b, r, total, chunk);
        finish_job(tag, n, s0, d0, exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        int d0;
        int i;

        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_outputs", {stream_start_o, done_o, err_o, trans_size_o, chunk_idx_o}, 0);
        check_eq("rst_bases", {base_a_o, base_b_o}, 0);

        run_job("t1", 32'h1000, 32'h2000, 32'h3000, 32'd10, 16'd4, 1'b0);
        run_job("t2", 32'h4000, 32'h5000, 32'h6000, 32'd8, 16'd8, 1'b0);
        run_job("t3_zero", 32'h10, 32'h20, 32'h30, 32'd0, 16'd4, 1'b0);
        run_job("t3_err", 32'h10, 32'h20, 32'h30, 32'd5, 16'd0, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("err_sticky", err_o, 1);

        // Stall in LAUNCH: streamers not ready.
        streams_ready_i = 1'b0;
        push_model(32'h7000, 32'h8000, 32'h9000, 32'd4, 16'd4, n);
        s0 = start_cnt; d0 = done_cnt;
        kick(32'h7000, 32'h8000, 32'h9000, 32'd4, 16'd4);
        check_eq("t4_err_cleared", err_o, 0);
        repeat (7) @(negedge clk);
        check_eq("t4_no_pulse_stall", start_cnt - s0, 0);
        check_eq("t4_busy_stall", busy_o, 1);
        streams_ready_i = 1'b1;
        finish_job("t4", n, s0, d0, 1'b0);

        // Clear while waiting on the second chunk.
        push_model(32'h100, 32'h200, 32'h300, 32'd12, 16'd4, n);
        s0 = start_cnt; d0 = done_cnt;
        kick(32'h100, 32'h200, 32'h300, 32'd12, 16'd4);
        for (i = 0; i < 200 && start_cnt < s0 + 2; i++) @(negedge clk);
        check_eq("t5_second_start", start_cnt - s0, 2);
        clear_i = 1'b1;
        sink_cnt = 0;
        @(negedge clk);
        clear_i = 1'b0;
        check_eq("t5_busy", busy_o, 0);
        check_eq("t5_ctrl_outs", {stream_start_o, done_o, err_o, trans_size_o, chunk_idx_o}, 0);
        check_eq("t5_bases", {base_a_o, base_b_o}, 0);
        check_eq("t5_base_res", base_res_o, 0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        check_eq("t5_no_done", done_cnt - d0, 0);
        run_job("t5_rerun", 32'hA000, 32'hB000, 32'hC000, 32'd9, 16'd4, 1'b0);

        // Address wrap, plus start/sink_done noise while busy.
        streams_ready_i = 1'b0;
        push_model(32'h100, 32'h200, 32'hFFFF_FFF8, 32'd8, 16'd4, n);
        check_eq("t6_model_wrap", exp_q[1].r, 32'h0000_0008);
        s0 = start_cnt; d0 = done_cnt;
        kick(32'h100, 32'h200, 32'hFFFF_FFF8, 32'd8, 16'd4);
        repeat (3) begin
            @(negedge clk);
            base_a_i = 32'hDEAD_0000; total_len_i = 32'd99;
            start_i = 1'b1; sink_done_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0; sink_done_i = 1'b0;
        end
        check_eq("t6_no_pulse_noise", start_cnt - s0, 0);
        streams_ready_i = 1'b1;
        finish_job("t6", n, s0, d0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
